// File: rtl/uart_pkg.sv
// Shared UART definitions: baud selection, divisor constants, oversample ratio and
// the receive/transmit FSM state type, common to uart_byte_rx and uart_byte_tx.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DIV_W      = 16;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_e;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  // Reference bps_DR divisors at the default 50 MHz system clock.
  localparam int unsigned REF_CLK_FREQ_HZ = 50_000_000;
  localparam int unsigned BPS_DR_9600     = REF_CLK_FREQ_HZ / 9600;
  localparam int unsigned BPS_DR_19200    = REF_CLK_FREQ_HZ / 19200;
  localparam int unsigned BPS_DR_38400    = REF_CLK_FREQ_HZ / 38400;
  localparam int unsigned BPS_DR_57600    = REF_CLK_FREQ_HZ / 57600;
  localparam int unsigned BPS_DR_115200   = REF_CLK_FREQ_HZ / 115200;

  // Unassigned selector codes fall back to 9600 baud.
  function automatic int unsigned baud_rate_hz(input logic [2:0] sel);
    case (sel)
      BAUD_19200:  return 19200;
      BAUD_38400:  return 38400;
      BAUD_57600:  return 57600;
      BAUD_115200: return 115200;
      default:     return 9600;
    endcase
  endfunction

  function automatic int unsigned bps_dr(input int unsigned clk_hz, input logic [2:0] sel);
    return clk_hz / baud_rate_hz(sel);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every `divisor` clocks while enabled.
module uart_baud_tick #(
  parameter int unsigned W = 16
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [W-1:0] divisor,
  input  logic         enable,
  input  logic         clear,
  output logic         tick
);

  logic [W-1:0] cnt;
  logic         wrap;

  assign wrap = (cnt == divisor - W'(1));
  assign tick = enable && !clear && wrap;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver, 16x oversampled, 8N1, LSB first.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at ticks 7/8/9.
module uart_byte_rx import uart_pkg::*; #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [2:0] baud_set,
  input  logic       uart_rx,
  output logic [7:0] Data,
  output logic       rx_done,
  output logic       frame_err
);

  localparam logic [DIV_W-1:0] TICK_DIV_9600   = DIV_W'(bps_dr(CLK_FREQ_HZ, BAUD_9600)   / OVERSAMPLE);
  localparam logic [DIV_W-1:0] TICK_DIV_19200  = DIV_W'(bps_dr(CLK_FREQ_HZ, BAUD_19200)  / OVERSAMPLE);
  localparam logic [DIV_W-1:0] TICK_DIV_38400  = DIV_W'(bps_dr(CLK_FREQ_HZ, BAUD_38400)  / OVERSAMPLE);
  localparam logic [DIV_W-1:0] TICK_DIV_57600  = DIV_W'(bps_dr(CLK_FREQ_HZ, BAUD_57600)  / OVERSAMPLE);
  localparam logic [DIV_W-1:0] TICK_DIV_115200 = DIV_W'(bps_dr(CLK_FREQ_HZ, BAUD_115200) / OVERSAMPLE);

  logic             rx_meta, rx_sync, rx_hist;
  logic [1:0]       sync_vld;
  logic             armed;
  logic             start_edge;
  logic [2:0]       baud_q;
  logic [DIV_W-1:0] tick_div;
  logic             tick;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             rx_done_q, frame_err_q;
  logic             sample_pt, bit_end, bit_val;
  logic             load_data, stop_err;

  uart_state_e state_q, state_d;

  // sync_vld marks when rx_sync carries the real line rather than its reset value,
  // so a line held low through reset never looks like a start edge.
  assign start_edge = (state_q == IDLE) && armed && rx_hist && !rx_sync;
  assign bit_end    = tick && (tick_cnt == 4'd15);

`ifdef UART_RX_MAJORITY_EN
  logic s7_q, s8_q;
  assign sample_pt = tick && (tick_cnt == 4'd9);
  assign bit_val   = (s7_q & s8_q) | (s7_q & rx_sync) | (s8_q & rx_sync);
`else
  assign sample_pt = tick && (tick_cnt == 4'd8);
  assign bit_val   = rx_sync;
`endif

  always_comb begin
    case (baud_q)
      BAUD_19200:  tick_div = TICK_DIV_19200;
      BAUD_38400:  tick_div = TICK_DIV_38400;
      BAUD_57600:  tick_div = TICK_DIV_57600;
      BAUD_115200: tick_div = TICK_DIV_115200;
      default:     tick_div = TICK_DIV_9600;
    endcase
  end

  uart_baud_tick #(.W(DIV_W)) u_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .divisor (tick_div),
    .enable  (state_q != IDLE),
    .clear   (start_edge),
    .tick    (tick)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    load_data = 1'b0;
    stop_err  = 1'b0;
    case (state_q)
      IDLE:  if (start_edge) state_d = START;
      START: begin
        if (sample_pt && bit_val) state_d = IDLE;
        else if (bit_end)         state_d = DATA;
      end
      DATA:  if (bit_end && bit_cnt == 3'd7) state_d = STOP;
      STOP: begin
        // Leave at the stop-bit sample point so a following start edge is not missed.
        if (sample_pt) begin
          state_d   = IDLE;
          load_data = bit_val;
          stop_err  = !bit_val;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_hist     <= 1'b1;
      sync_vld    <= 2'b00;
      armed       <= 1'b0;
      baud_q      <= BAUD_9600;
      tick_cnt    <= 4'd0;
      bit_cnt     <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta     <= uart_rx;
      rx_sync     <= rx_meta;
      rx_hist     <= rx_sync;
      sync_vld    <= {sync_vld[0], 1'b1};
      rx_done_q   <= load_data;
      frame_err_q <= stop_err;
      if (sync_vld[1] && rx_sync) armed <= 1'b1;
      if (load_data) data_q <= shift_q;

      if (state_q == IDLE) begin
        tick_cnt <= 4'd0;
        bit_cnt  <= 3'd0;
        if (start_edge) baud_q <= baud_set;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 4'd1;
        if (state_q == DATA && sample_pt) shift_q <= {bit_val, shift_q[7:1]};
        if (state_q == DATA && bit_end)   bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

`ifdef UART_RX_MAJORITY_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s7_q <= 1'b1;
      s8_q <= 1'b1;
    end else if (tick) begin
      if (tick_cnt == 4'd7) s7_q <= rx_sync;
      if (tick_cnt == 4'd8) s8_q <= rx_sync;
    end
  end
`endif

  assign Data      = data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: scoreboard of expected bytes, scenario tasks.
`timescale 1ns/1ps
module tb_uart_byte_rx;
  import uart_pkg::*;

  // 9.216 MHz gives exact 16x divisors at 9600 (60) and 115200 (5).
  localparam int unsigned CLK_HZ = 9_216_000;
  localparam int BIT_9600   = CLK_HZ / 9600;
  localparam int BIT_115200 = CLK_HZ / 115200;
  localparam int GLITCH_CYC = (3 * CLK_HZ) / 1_000_000;
  // Cycle within a bit that the receiver's tick-8 sample sees after synchronisation.
  localparam int SPIKE_OFF  = 45;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [2:0] baud_set = 3'd0;
  logic       uart_rx = 1'b0;
  logic [7:0] Data;
  logic       rx_done;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc = 0;
  int cyc = 0;
  int frame_start_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;

  uart_byte_rx #(.CLK_FREQ_HZ(CLK_HZ)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .baud_set  (baud_set),
    .uart_rx   (uart_rx),
    .Data      (Data),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  // Scoreboard monitor: every rx_done pops one expected byte.
  always @(negedge Clk) begin
    if (rx_done || frame_err) begin
      checks++;
      if (rx_done && frame_err) begin
        errors++;
        $display("FAIL done_err_overlap: rx_done=%b frame_err=%b, required not both", rx_done, frame_err);
      end
    end
    if (frame_err) err_cnt++;
    if (rx_done) begin
      done_cnt++;
      done_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: rx_done with Data=%h, none expected", Data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (Data !== sb_exp) begin
          errors++;
          $display("FAIL scoreboard_data: Data=%h, required %h", Data, sb_exp);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int bit_cyc, input bit spike);
    logic [9:0] bits;
    bits = {stop_val, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < bit_cyc; c++) begin
        @(negedge Clk);
        if (i == 0 && c == 0) frame_start_cyc = cyc;
        uart_rx = (spike && i >= 1 && i <= 8 && c == SPIKE_OFF) ? ~bits[i] : bits[i];
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic test_reset;
    baud_set = BAUD_115200;
    uart_rx  = 1'b0;
    wait_cyc(3);
    checks++; if (Data !== 8'h00)    begin errors++; $display("FAIL reset_data: %h, required 00", Data); end
    checks++; if (rx_done !== 1'b0)  begin errors++; $display("FAIL reset_rx_done: %b, required 0", rx_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: %b, required 0", frame_err); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: %0d, required IDLE", dut.state_q); end
    Reset_n = 1'b1;
    wait_cyc(12 * BIT_115200);
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL low_after_reset_done: %0d pulses, required 0", done_cnt); end
    checks++; if (err_cnt !== 0)  begin errors++; $display("FAIL low_after_reset_err: %0d pulses, required 0", err_cnt); end
    uart_rx = 1'b1;
    wait_cyc(2 * BIT_115200);
  endtask

  task automatic test_single_115200;
    int d0, e0, dt;
    d0 = done_cnt; e0 = err_cnt;
    baud_set = BAUD_115200;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, BIT_115200, 1'b0);
      begin wait_cyc(5 * BIT_115200); baud_set = BAUD_9600; end
    join
    wait_cyc(2 * BIT_115200);
    baud_set = BAUD_115200;
    dt = 2 * (done_cyc - frame_start_cyc);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL a5_done_count: %0d, required 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0)  begin errors++; $display("FAIL a5_frame_err: %0d, required 0", err_cnt - e0); end
    checks++; if (Data !== 8'hA5)      begin errors++; $display("FAIL a5_data: %h, required a5", Data); end
    checks++;
    if (dt < 17 * BIT_115200 || dt > 21 * BIT_115200) begin
      errors++;
      $display("FAIL a5_latency: %0d half-cycles, required %0d..%0d", dt, 17 * BIT_115200, 21 * BIT_115200);
    end
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = done_cnt;
    baud_set = BAUD_9600;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    send_frame(8'h00, 1'b1, BIT_9600, 1'b0);
    send_frame(8'hFF, 1'b1, BIT_9600, 1'b0);
    send_frame(8'h55, 1'b1, BIT_9600, 1'b0);
    wait_cyc(2 * BIT_9600);
    checks++; if (done_cnt - d0 !== 3) begin errors++; $display("FAIL b2b_done_count: %0d, required 3", done_cnt - d0); end
    checks++; if (exp_q.size() !== 0)  begin errors++; $display("FAIL b2b_pending: %0d left, required 0", exp_q.size()); end
    checks++; if (Data !== 8'h55)      begin errors++; $display("FAIL b2b_last_data: %h, required 55", Data); end
  endtask

  task automatic test_glitch;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    baud_set = BAUD_115200;
    @(negedge Clk) uart_rx = 1'b0;
    wait_cyc(GLITCH_CYC);
    uart_rx = 1'b1;
    wait_cyc(3 * BIT_115200);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL glitch_done: %0d, required 0", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0)  begin errors++; $display("FAIL glitch_err: %0d, required 0", err_cnt - e0); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL glitch_state: %0d, required IDLE", dut.state_q); end
  endtask

  task automatic test_frame_err;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    baud_set = BAUD_115200;
    send_frame(8'h3C, 1'b0, BIT_115200, 1'b0);
    // Line held low long enough that a wrongly restarted frame would report again.
    wait_cyc(12 * BIT_115200);
    checks++; if (err_cnt - e0 !== 1)  begin errors++; $display("FAIL ferr_pulse: %0d cycles, required 1", err_cnt - e0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL ferr_done: %0d, required 0", done_cnt - d0); end
    checks++; if (Data !== 8'h55)      begin errors++; $display("FAIL ferr_data: %h, required 55", Data); end
    uart_rx = 1'b1;
    wait_cyc(2 * BIT_115200);
  endtask

  task automatic test_reset_abort;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    baud_set = BAUD_115200;
    fork
      send_frame(8'hC3, 1'b1, BIT_115200, 1'b0);
      begin
        wait_cyc(5 * BIT_115200 + BIT_115200 / 2);
        Reset_n = 1'b0;
        wait_cyc(3);
        Reset_n = 1'b1;
      end
    join
    wait_cyc(2 * BIT_115200);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL abort_done: %0d, required 0", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0)  begin errors++; $display("FAIL abort_err: %0d, required 0", err_cnt - e0); end
    checks++; if (Data !== 8'h00)      begin errors++; $display("FAIL abort_data: %h, required 00", Data); end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, BIT_115200, 1'b0);
    wait_cyc(2 * BIT_115200);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL after_abort_done: %0d, required 1", done_cnt - d0); end
    checks++; if (Data !== 8'h81)      begin errors++; $display("FAIL after_abort_data: %h, required 81", Data); end
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority;
    int d0;
    d0 = done_cnt;
    baud_set = BAUD_115200;
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, BIT_115200, 1'b1);
    wait_cyc(2 * BIT_115200);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL maj_done: %0d, required 1", done_cnt - d0); end
    checks++; if (Data !== 8'h96)      begin errors++; $display("FAIL maj_data: %h, required 96", Data); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_115200();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_abort();
`ifdef UART_RX_MAJORITY_EN
    test_majority();
`endif
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d bytes never received, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
